mem_bus_arbiter: RTL

Sequential arbiter that shares the CPU's single 16-bit memory port between the multi-cycle CPU and a DMA engine. It sits between the CPU memory interface (readM/writeM/address/data) and the memory model. It serialises accesses, counts fixed memory latency, and runs the BR/BG bus-request/bus-grant handshake with the DMA engine. The CPU sees a request/acknowledge interface and stalls while the DMA engine owns the bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_latency_counter.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA memory bus arbiter.
// Optional statistics counter is enabled with the ARB_STATS_EN macro.
package mem_bus_arbiter_pkg;

  localparam int ARB_WORD_SIZE = 16;

  localparam int ARB_MEM_LATENCY = 2;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_CPU_ACC = 3'd1,
    ARB_CPU_ACK = 3'd2,
    ARB_DMA_GNT = 3'd3,
    ARB_DMA_ACC = 3'd4
  } arb_state_e;

  // One spare bit so a latency of 1 still yields a non-zero width.
  function automatic int lat_cnt_width(input int latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_latency_counter.sv
// Loadable down-counter with a zero flag; times every memory access.
// Holds at zero rather than wrapping.
module latency_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between a multi-cycle CPU and a DMA engine (BR/BG handshake).
// Define ARB_STATS_EN to add the cpu_stall_cycles counter port.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = ARB_WORD_SIZE,
  parameter int MEM_LATENCY = ARB_MEM_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 dma_br,
  output logic                 dma_bg,
  input  logic                 dma_req,
  input  logic [WORD_SIZE-1:0] dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic                 dma_ack,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] cpu_stall_cycles
`endif
);

  localparam int               CNT_W    = lat_cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e           r_state;
  logic                 r_cpu_ack;
  logic                 r_dma_ack;
  logic                 r_dma_bg;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [WORD_SIZE-1:0] r_cpu_rdata;

  logic w_cpu_start;
  logic w_dma_start;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;

  // DMA wins over a simultaneous CPU request in IDLE.
  assign w_cpu_start = (r_state == ARB_IDLE) && !dma_br && cpu_req;
  assign w_dma_start = (r_state == ARB_DMA_GNT) && dma_req;
  assign w_cnt_load  = w_cpu_start || w_dma_start;
  assign w_cnt_dec   = (r_state == ARB_CPU_ACC) || (r_state == ARB_DMA_ACC);

  latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_dma_bg    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          // Grant may still be high here for the ack cycle of a finished DMA write.
          r_dma_bg <= dma_br;
          if (dma_br) begin
            r_state <= ARB_DMA_GNT;
          end else if (cpu_req) begin
            r_state     <= ARB_CPU_ACC;
            r_mem_read  <= !cpu_we;
            r_mem_write <= cpu_we;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
          end
        end

        ARB_CPU_ACC: begin
          if (w_cnt_zero) begin
            r_state     <= ARB_CPU_ACK;
            r_cpu_ack   <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) begin
              r_cpu_rdata <= mem_rdata;
            end
          end
        end

        ARB_CPU_ACK: begin
          r_state <= ARB_IDLE;
        end

        ARB_DMA_GNT: begin
          if (dma_req) begin
            r_state     <= ARB_DMA_ACC;
            r_mem_write <= 1'b1;
            r_mem_addr  <= dma_addr;
            r_mem_wdata <= dma_wdata;
          end else if (!dma_br) begin
            r_state  <= ARB_IDLE;
            r_dma_bg <= 1'b0;
          end
        end

        ARB_DMA_ACC: begin
          if (w_cnt_zero) begin
            r_mem_write <= 1'b0;
            r_dma_ack   <= 1'b1;
            r_state     <= dma_br ? ARB_DMA_GNT : ARB_IDLE;
          end
        end

        default: begin
          r_state     <= ARB_IDLE;
          r_dma_bg    <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_bg    = r_dma_bg;
  assign dma_ack   = r_dma_ack;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef ARB_STATS_EN
  logic                 w_stall_cond;
  logic [WORD_SIZE-1:0] r_stall_cycles;

  assign w_stall_cond = cpu_req &&
                        (((r_state == ARB_IDLE) && dma_br) ||
                         (r_state == ARB_DMA_GNT) ||
                         (r_state == ARB_DMA_ACC));

  // Saturating count of cycles the CPU waited on the DMA engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall_cond && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + WORD_SIZE'(1);
    end
  end

  assign cpu_stall_cycles = r_stall_cycles;
`endif

endmodule
